// File: rtl/draw_select_frame_pkg.sv
// rtl/draw_select_frame_pkg.sv - shared VGA bus layout and memory-game grid geometry
// Purpose: one place for the VGA bus record and the grid constants used by all draw/pick stages.
// Contents: VGA_BUS_SIZE, vga_bus_t (bus split/merge by field), grid origin, card size, gap, grid size.
package draw_select_frame_pkg;

  localparam int VGA_BUS_SIZE  = 38;

  localparam int VGA_GRID_X0   = 64;
  localparam int VGA_GRID_Y0   = 48;
  localparam int VGA_CARD_W    = 208;
  localparam int VGA_CARD_H    = 150;
  localparam int VGA_GAP       = 32;
  localparam int VGA_GRID_SIZE = 4;

  // Field order defines the flat bus layout; packing/unpacking is a plain cast.
  typedef struct packed {
    logic [10:0] hcount;
    logic        hs;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vs;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_bus_t;

endpackage

// File: rtl/draw_select_frame_if.sv
// rtl/draw_select_frame_if.sv - VGA bus interface between draw stages
// Purpose: carries one vga_bus_t record from one pipeline stage to the next.
// Modports: master drives bus, slave receives bus.
interface draw_select_frame_if;
  import draw_select_frame_pkg::*;

  vga_bus_t bus;

  modport master (output bus);
  modport slave  (input  bus);

endinterface

// File: rtl/draw_select_frame_vga_bus_delay.sv
// rtl/draw_select_frame_vga_bus_delay.sv - N-stage register of the whole VGA bus
// Purpose: aligns the VGA bus with registered overlay decisions in the draw stages.
// Ports: pclk (clock), rst (sync active-high, clears all stages), bus_in, bus_out (N cycles later).
module vga_bus_delay
  import draw_select_frame_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic [VGA_BUS_SIZE-1:0] bus_in,
  output logic [VGA_BUS_SIZE-1:0] bus_out
);

  logic [VGA_BUS_SIZE-1:0] stage [N];

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) stage[i] <= '0;
    end else begin
      stage[0] <= bus_in;
      for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign bus_out = stage[N-1];

endmodule

// File: rtl/draw_select_frame.sv
// rtl/draw_select_frame.sv - overlays a frame around the selected card of the 4x4 grid
// Purpose: re-emits the VGA bus 2 pclk later with FRAME_COLOR drawn in a FRAME_T-wide ring
//   around the selected card. Selection is sampled only at vsync rise so a frame never tears.
// Ports: pclk, rst (sync active-high), vga_in (slave bus), vga_out (master bus, 2-cycle latency),
//   sel_col/sel_row (selected card), sel_valid (a selection exists).
// Build option: SELECT_FRAME_BLINK_EN adds a vsync-driven blink of BLINK_FRAMES frames per phase;
//   without it the frame is drawn steadily whenever a selection is active.
module draw_select_frame
  import draw_select_frame_pkg::*;
#(
  parameter int          GRID_X0     = VGA_GRID_X0,
  parameter int          GRID_Y0     = VGA_GRID_Y0,
  parameter int          CARD_W      = VGA_CARD_W,
  parameter int          CARD_H      = VGA_CARD_H,
  parameter int          GAP         = VGA_GAP,
  parameter int          FRAME_T     = 4,
  parameter logic [11:0] FRAME_COLOR = 12'hFF0
`ifdef SELECT_FRAME_BLINK_EN
  , parameter int        BLINK_FRAMES = 30
`endif
) (
  input  logic                               pclk,
  input  logic                               rst,
  draw_select_frame_if.slave                 vga_in,
  draw_select_frame_if.master                vga_out,
  input  logic [$clog2(VGA_GRID_SIZE)-1:0]   sel_col,
  input  logic [$clog2(VGA_GRID_SIZE)-1:0]   sel_row,
  input  logic                               sel_valid
);

  localparam logic [10:0] X0_BASE = 11'(GRID_X0);
  localparam logic [10:0] Y0_BASE = 11'(GRID_Y0);
  localparam logic [10:0] PITCH_X = 11'(CARD_W + GAP);
  localparam logic [10:0] PITCH_Y = 11'(CARD_H + GAP);
  localparam logic [10:0] FT      = 11'(FRAME_T);
  localparam logic [10:0] CW      = 11'(CARD_W);
  localparam logic [10:0] CH      = 11'(CARD_H);

  logic        vs_prev;
  logic        vs_rise;
  logic        active;
  // x0/y0 hold the latched column/row as pixel coordinates; column/row 0 maps to the grid origin.
  logic [10:0] x0, y0;
  logic        blink_on;

  vga_bus_t    bus_s1, bus_s2;
  logic        in_outer, in_card;
  logic        in_outer_c, in_card_c;
  logic        draw;

  assign vs_rise = vga_in.bus.vs & ~vs_prev;

  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_prev <= 1'b0;
      active  <= 1'b0;
      x0      <= X0_BASE;
      y0      <= Y0_BASE;
    end else begin
      vs_prev <= vga_in.bus.vs;
      if (vs_rise) begin
        active <= sel_valid;
        // Constant-coefficient products only in the once-per-frame latch path.
        x0     <= X0_BASE + 11'(sel_col) * PITCH_X;
        y0     <= Y0_BASE + 11'(sel_row) * PITCH_Y;
      end
    end
  end

`ifdef SELECT_FRAME_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [CNT_W-1:0] frame_cnt;

  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (vs_rise) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  assign blink_on = 1'b1;
`endif

  // Stage 1 geometry: inclusive bounds, 11-bit unsigned.
  always_comb begin
    in_outer_c = (vga_in.bus.hcount >= x0 - FT) && (vga_in.bus.hcount <= x0 + CW + FT - 11'd1) &&
                 (vga_in.bus.vcount >= y0 - FT) && (vga_in.bus.vcount <= y0 + CH + FT - 11'd1);
    in_card_c  = (vga_in.bus.hcount >= x0) && (vga_in.bus.hcount <= x0 + CW - 11'd1) &&
                 (vga_in.bus.vcount >= y0) && (vga_in.bus.vcount <= y0 + CH - 11'd1);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      in_outer <= 1'b0;
      in_card  <= 1'b0;
    end else begin
      in_outer <= in_outer_c;
      in_card  <= in_card_c;
    end
  end

  vga_bus_delay #(.N(1)) u_stage1 (
    .pclk    (pclk),
    .rst     (rst),
    .bus_in  (vga_in.bus),
    .bus_out (bus_s1)
  );

  // Blanking is taken from the stage-1 bus so it lines up with the registered geometry.
  assign draw = in_outer & ~in_card & active & blink_on & ~bus_s1.hblnk & ~bus_s1.vblnk;

  always_ff @(posedge pclk) begin
    if (rst) begin
      bus_s2 <= '0;
    end else begin
      bus_s2     <= bus_s1;
      bus_s2.rgb <= draw ? FRAME_COLOR : bus_s1.rgb;
    end
  end

  assign vga_out.bus = bus_s2;

endmodule

// File: tb/tb_draw_select_frame.sv
// tb/tb_draw_select_frame.sv - directed self-checking bench for draw_select_frame
module tb_draw_select_frame;
  import draw_select_frame_pkg::*;

  localparam logic [11:0] FC = 12'hFF0;
  localparam logic [11:0] BG = 12'h123;

  logic       pclk;
  logic       rst;
  logic [1:0] sel_col, sel_row;
  logic       sel_valid;
  int         n_cmp;
  int         n_bad;

  draw_select_frame_if vin ();
  draw_select_frame_if vout ();

  draw_select_frame dut (
    .pclk      (pclk),
    .rst       (rst),
    .vga_in    (vin),
    .vga_out   (vout),
    .sel_col   (sel_col),
    .sel_row   (sel_row),
    .sel_valid (sel_valid)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold one pixel for two edges so the output shows exactly this pixel.
  task automatic pix(input string tag, input logic [10:0] h, input logic [10:0] v,
                     input logic hb, input logic vb, input logic [11:0] exp_rgb);
    vin.bus.hcount = h;
    vin.bus.vcount = v;
    vin.bus.hs     = 1'b0;
    vin.bus.vs     = 1'b0;
    vin.bus.hblnk  = hb;
    vin.bus.vblnk  = vb;
    vin.bus.rgb    = BG;
    @(posedge pclk); @(posedge pclk); #1;
    check(tag, 64'(vout.bus.rgb), 64'(exp_rgb));
  endtask

  // vs held high for several cycles: must count as a single edge.
  task automatic vsync(input logic [1:0] c, input logic [1:0] r, input logic valid);
    sel_col   = c;
    sel_row   = r;
    sel_valid = valid;
    vin.bus.vs = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    vin.bus.vs = 1'b0;
    @(posedge pclk); #1;
  endtask

  logic [VGA_BUS_SIZE-1:0] hist [32];
  logic [63:0]             rnd;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    sel_col = 2'd0; sel_row = 2'd0; sel_valid = 1'b0;
    vin.bus = '0;
    vin.bus.hcount = 11'd303;
    vin.bus.vcount = 11'd500;
    vin.bus.rgb    = 12'hABC;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_out", 64'(vout.bus), 64'd0);
    rst = 1'b0;

    // Pass-through with no selection: bit-exact 2-cycle delay.
    for (int i = 0; i < 32; i++) begin
      rnd = {$urandom(), $urandom()};
      hist[i] = rnd[VGA_BUS_SIZE-1:0];
      vin.bus = hist[i];
      @(posedge pclk); #1;
      if (i >= 1) check($sformatf("delay_%0d", i), 64'(vout.bus), 64'(hist[i-1]));
    end
    vin.bus.vs = 1'b0;
    @(posedge pclk); #1;

    // Column 1, row 2: outer ring 300..515 x 408..565, card 304..511 x 412..561.
    vsync(2'd1, 2'd2, 1'b1);
    pix("c1r2_tl_outer", 11'd300, 11'd408, 1'b0, 1'b0, FC);
    pix("c1r2_br_outer", 11'd515, 11'd565, 1'b0, 1'b0, FC);
    pix("c1r2_left_in",  11'd303, 11'd500, 1'b0, 1'b0, FC);
    pix("c1r2_card",     11'd304, 11'd500, 1'b0, 1'b0, BG);
    pix("c1r2_left_out", 11'd299, 11'd408, 1'b0, 1'b0, BG);
    pix("c1r2_right_out",11'd516, 11'd500, 1'b0, 1'b0, BG);
    pix("c1r2_top_out",  11'd300, 11'd407, 1'b0, 1'b0, BG);

    // Mid-frame change is ignored until the next vsync rise.
    sel_col = 2'd3;
    pix("mid_old_frame", 11'd300, 11'd408, 1'b0, 1'b0, FC);
    pix("mid_new_absent",11'd780, 11'd408, 1'b0, 1'b0, BG);
    vsync(2'd3, 2'd2, 1'b1);
    pix("next_left_edge",11'd780, 11'd408, 1'b0, 1'b0, FC);
    pix("next_left_out", 11'd779, 11'd408, 1'b0, 1'b0, BG);
    pix("next_old_gone", 11'd300, 11'd408, 1'b0, 1'b0, BG);

    // Column 3, row 3: ring 780..995 x 590..747; blanking overrides geometry.
    vsync(2'd3, 2'd3, 1'b1);
    pix("c3r3_tl",       11'd780, 11'd590, 1'b0, 1'b0, FC);
    pix("c3r3_br",       11'd995, 11'd747, 1'b0, 1'b0, FC);
    pix("c3r3_right_out",11'd996, 11'd747, 1'b0, 1'b0, BG);
    pix("c3r3_card",     11'd784, 11'd594, 1'b0, 1'b0, BG);
    pix("c3r3_hblnk",    11'd780, 11'd590, 1'b1, 1'b0, BG);
    pix("c3r3_vblnk",    11'd780, 11'd590, 1'b0, 1'b1, BG);

    // Reset mid-frame while drawing.
    pix("pre_rst_draw",  11'd780, 11'd600, 1'b0, 1'b0, FC);
    rst = 1'b1;
    @(posedge pclk); #1;
    check("rst_out_zero", 64'(vout.bus), 64'd0);
    rst = 1'b0;
    @(posedge pclk); #1;
    check("rst_refill_1", 64'(vout.bus), 64'd0);
    @(posedge pclk); #1;
    check("rst_refill_rgb", 64'(vout.bus.rgb), 64'(BG));
    check("rst_refill_h",   64'(vout.bus.hcount), 64'd780);
    pix("rst_no_frame",  11'd780, 11'd600, 1'b0, 1'b0, BG);
    vsync(2'd3, 2'd3, 1'b1);
    pix("rst_frame_back",11'd780, 11'd600, 1'b0, 1'b0, FC);

    // Reset coinciding with a vsync rise: reset wins.
    sel_valid  = 1'b1;
    vin.bus.vs = 1'b1;
    rst = 1'b1;
    @(posedge pclk); #1;
    rst = 1'b0;
    vin.bus.vs = 1'b0;
    @(posedge pclk); #1;
    pix("rst_vs_same",   11'd780, 11'd600, 1'b0, 1'b0, BG);

`ifdef SELECT_FRAME_BLINK_EN
    rst = 1'b1;
    @(posedge pclk); #1;
    rst = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      vsync(2'd3, 2'd3, 1'b1);
      if (k == 1 || k == 29)
        pix($sformatf("blink_on_%0d", k),  11'd780, 11'd600, 1'b0, 1'b0, FC);
      if (k == 30 || k == 59)
        pix($sformatf("blink_off_%0d", k), 11'd780, 11'd600, 1'b0, 1'b0, BG);
      if (k == 60)
        pix($sformatf("blink_on_%0d", k),  11'd780, 11'd600, 1'b0, 1'b0, FC);
    end
`else
    vsync(2'd3, 2'd3, 1'b1);
    for (int k = 1; k <= 35; k++) vsync(2'd3, 2'd3, 1'b1);
    pix("steady_after_35", 11'd780, 11'd600, 1'b0, 1'b0, FC);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/draw_select_frame.md
Name: draw_select_frame

Overview:
- Downstream stage of the VGA timing generator; consumes the VGA bus (hcount, vcount, hs, vs, hblnk, vblnk, rgb) and re-emits it with a coloured frame drawn around the currently selected card of the 4x4 memory-game grid.
- Selection is latched once per frame at vsync start, so the frame never tears mid-frame.
- Optional blinking is driven by a vsync-edge frame counter.

Parameters:
- GRID_X0, 64, x of column-0 card left edge (pixels)
- GRID_Y0, 48, y of row-0 card top edge
- CARD_W, 208, card width
- CARD_H, 150, card height
- GAP, 32, spacing between cards (both axes)
- FRAME_T, 4, frame thickness outside the card rectangle
- FRAME_COLOR, 12'hF_F_0, frame rgb
- BLINK_FRAMES, 30, frames per blink phase

Ports:
- pclk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- vga_in  in  VGA_BUS_SIZE  VGA bus from the upstream stage
- sel_col  in  2  selected column, 0..3
- sel_row  in  2  selected row, 0..3
- sel_valid  in  1  level: a selection exists
- vga_out  out  VGA_BUS_SIZE  VGA bus, delayed 2 cycles, frame overlaid

Behaviour:
- Reset is rst, synchronous, active-high; clock is pclk.
- Reset values:
  - all vga_out fields 0
  - latched col/row 0, active 0
  - frame_cnt 0, blink_on 1
  - vs_prev 0
- Latency: exactly 2 pclk. hcount, vcount, hs, vs, hblnk and vblnk pass through two register stages unchanged; rgb is muxed in stage 2.
- Vsync edge: vs_rise = vs_in & ~vs_prev, with vs_prev registered each cycle.
- On vs_rise:
  - active <= sel_valid
  - lat_col <= sel_col, lat_row <= sel_row
  - x0 <= GRID_X0 + lat_col_new*(CARD_W+GAP)
  - y0 <= GRID_Y0 + lat_row_new*(CARD_H+GAP)
  - x0/y0 are registered 11-bit values; no multiplier in the pixel path.
- Sel inputs at any other cycle are ignored. A change mid-frame takes effect at the next vs_rise.
- Stage 1 registers the geometry tests (all comparisons 11-bit unsigned, inclusive bounds):
  - in_outer = x0-FRAME_T <= h <= x0+CARD_W+FRAME_T-1, and y0-FRAME_T <= v <= y0+CARD_H+FRAME_T-1
  - in_card = x0 <= h <= x0+CARD_W-1, and y0 <= v <= y0+CARD_H-1
- Stage 2:
  - draw = in_outer & ~in_card & active & blink_on & ~hblnk & ~vblnk
  - rgb_out = draw ? FRAME_COLOR : delayed rgb_in
- Blink, on vs_rise:
  - if frame_cnt == BLINK_FRAMES-1: frame_cnt <= 0 and blink_on <= ~blink_on
  - else frame_cnt++
  - Counter width is clog2(BLINK_FRAMES).
- Boundaries:
  - A pixel on the outer edge is drawn; the first pixel inside the card is not.
  - The blanking suppression wins over geometry.
  - vs held high across many cycles counts as one edge.
  - rst mid-frame clears the pipeline; outputs stay 0 until the pipeline refills 2 cycles after rst falls; active stays 0 until the next vs_rise.
  - rst and vs_rise in the same cycle: rst wins.

Optional Feature:
- SELECT_FRAME_BLINK_EN.
- Defined: blink behaviour as above.
- Undefined: frame_cnt and blink_on logic are not instantiated; blink_on is a constant 1; the frame is drawn steadily whenever active.

Decomposition:
- Shared package/header _vga_macros.vh holds:
  - VGA_BUS_SIZE
  - the bus split/merge macros
  - grid geometry constants (GRID_X0, GRID_Y0, CARD_W, CARD_H, GAP, grid size 4), shared with the card-draw and mouse-pick stages
- One sub-module is natural: vga_bus_delay (parameterised N-stage register of the whole bus, reset to 0). It is also reused by the other draw stages.

Test Plan:
- Reset, then a full frame with sel_valid=0: vga_out equals vga_in delayed 2 cycles, bit-exact, for every pixel.
- sel_col=1, sel_row=2, sel_valid=1 latched at vs_rise (define SELECT_FRAME_BLINK_EN off):
  - rgb=12'hFF0 at (300,408), (515,565), (303,500)
  - pass-through rgb at (304,500), (299,408), (516,500), (300,407)
- Change sel_col to 3 mid-frame at vcount 300: the frame stays at col 1 until the next vs_rise; the next frame's left edge is at h=780.
- Blink on, BLINK_FRAMES=30: the frame is visible in frames 0-29 after reset, absent in 30-59, and visible again from 60; frame_cnt wraps 29->0.
- Selection at col 3, row 3: the frame spans h 780..995, v 590..747. Force hblnk=1 inside that region: the pass-through rgb is used.
- Assert rst for 1 cycle at hcount 500 while drawing: outputs are 0 on the next cycle, the pipeline resumes after 2 cycles, and the frame is absent until after the next vs_rise.
